// File: rtl/halton_point_scheduler_if.sv
// Requester / core / point-stream bundle for halton_point_scheduler.
// slave  = the scheduler side, master = the environment (requesters, core, consumer).
interface halton_point_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       grant;
  logic                     reseed_req;
  logic [31:0]              reseed_value;
  logic                     reseed_ack;
  logic                     gen_pop_enable;
  logic                     gen_reseed_enable;
  logic [31:0]              gen_seed;
  logic [31:0]              gen_out_0;
  logic [31:0]              gen_out_1;
  logic                     gen_valid;
  logic [31:0]              pt_x;
  logic [31:0]              pt_y;
  logic [ID_W-1:0]          pt_id;
  logic                     pt_valid;
  logic                     pt_ready;
  logic                     pt_last;
  logic                     busy;
  logic                     timeout_err;
  logic [31:0]              pts_served;

  modport slave (
    input  req, req_len, reseed_req, reseed_value, gen_out_0, gen_out_1, gen_valid, pt_ready,
    output grant, reseed_ack, gen_pop_enable, gen_reseed_enable, gen_seed,
           pt_x, pt_y, pt_id, pt_valid, pt_last, busy, timeout_err, pts_served
  );

  modport master (
    output req, req_len, reseed_req, reseed_value, gen_out_0, gen_out_1, gen_valid, pt_ready,
    input  grant, reseed_ack, gen_pop_enable, gen_reseed_enable, gen_seed,
           pt_x, pt_y, pt_id, pt_valid, pt_last, busy, timeout_err, pts_served
  );
endinterface

// File: rtl/halton_point_scheduler.sv
// Round-robin scheduler sharing one 2-D Halton generator core among NUM_REQ requesters.
// Grants whole bursts, pops the core one point at a time, streams points out tagged with
// the requester id, serialises reseeds between bursts and aborts a burst on core timeout.
module halton_point_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 64
) (
  input logic                      clk,
  input logic                      rst_n,
  halton_point_scheduler_if.slave  bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RESEED = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [LEN_W:0]     rem_q, rem_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic [31:0]        x_q, x_d;
  logic [31:0]        y_q, y_d;
  logic [31:0]        seed_q, seed_d;
  logic [31:0]        served_q, served_d;

  logic               pick_found;
  logic [ID_W-1:0]    pick_id;
  logic [ID_W:0]      scan_idx;
  logic [ID_W-1:0]    rr_after_id;
  logic               wait_expired;

  // Circular priority scan: first requester at or after the rr pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, rr_q} + (ID_W + 1)'(i);
      if (scan_idx >= (ID_W + 1)'(NUM_REQ)) scan_idx = scan_idx - (ID_W + 1)'(NUM_REQ);
      if (!pick_found && bus.req[scan_idx[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = scan_idx[ID_W-1:0];
      end
    end
  end

  // Pointer value that puts the requester after the current winner on top.
  always_comb begin
    if (int'(id_q) == NUM_REQ - 1) rr_after_id = '0;
    else                           rr_after_id = id_q + ID_W'(1);
  end

  assign wait_expired = (wcnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state logic for the burst FSM and its datapath registers.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    id_d     = id_q;
    rr_d     = rr_q;
    rem_d    = rem_q;
    wcnt_d   = wcnt_q;
    x_d      = x_q;
    y_d      = y_q;
    seed_d   = seed_q;
    served_d = served_q;
    case (state_q)
      S_IDLE: begin
        if (bus.reseed_req) begin
          seed_d  = bus.reseed_value;
          state_d = S_RESEED;
        end else if (pick_found) begin
          id_d    = pick_id;
          rem_d   = {1'b0, bus.req_len[int'(pick_id) * LEN_W +: LEN_W]} + (LEN_W + 1)'(1);
          grant_d = NUM_REQ'(1) << pick_id;
          state_d = S_ISSUE;
        end
      end
      S_RESEED: state_d = S_IDLE;
      S_ISSUE: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A valid arriving on the final allowed cycle still counts as a hit.
        if (bus.gen_valid) begin
          x_d     = bus.gen_out_0;
          y_d     = bus.gen_out_1;
          state_d = S_OUT;
        end else if (wait_expired) begin
          grant_d = '0;
          rr_d    = rr_after_id;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      S_OUT: begin
        if (bus.pt_ready) begin
          served_d = served_q + 32'd1;
          if (rem_q == (LEN_W + 1)'(1)) begin
            grant_d = '0;
            rr_d    = rr_after_id;
            state_d = S_IDLE;
          end else begin
            rem_d   = rem_q - (LEN_W + 1)'(1);
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      id_q     <= '0;
      rr_q     <= '0;
      rem_q    <= '0;
      wcnt_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      seed_q   <= '0;
      served_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      id_q     <= id_d;
      rr_q     <= rr_d;
      rem_q    <= rem_d;
      wcnt_q   <= wcnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      seed_q   <= seed_d;
      served_q <= served_d;
    end
  end

  assign bus.grant             = grant_q;
  assign bus.reseed_ack        = (state_q == S_RESEED);
  assign bus.gen_reseed_enable = (state_q == S_RESEED);
  assign bus.gen_pop_enable    = (state_q == S_ISSUE);
  assign bus.gen_seed          = seed_q;
  assign bus.pt_x              = x_q;
  assign bus.pt_y              = y_q;
  assign bus.pt_id             = id_q;
  assign bus.pt_valid          = (state_q == S_OUT);
  assign bus.pt_last           = (state_q == S_OUT) && (rem_q == (LEN_W + 1)'(1));
  assign bus.busy              = (state_q != S_IDLE);
  assign bus.timeout_err       = (state_q == S_WAIT) && !bus.gen_valid && wait_expired;
  assign bus.pts_served        = served_q;
endmodule

// File: tb/tb_halton_point_scheduler.sv
// Directed bench for halton_point_scheduler with a behavioural Halton core stand-in.
module tb_halton_point_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  halton_point_scheduler_if #(.NUM_REQ(4), .LEN_W(8)) bus ();
  halton_point_scheduler #(.NUM_REQ(4), .LEN_W(8), .TIMEOUT(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Core stand-in: index k advances on each pop, output for index k appears core_lat
  // cycles later (core_lat=1 means valid during the first WAIT cycle).
  int unsigned core_k = 0;
  int unsigned core_lat = 1;
  int unsigned core_cnt;
  bit          core_stall = 1'b0;
  int unsigned pops = 0;

  function automatic logic [63:0] core_pt(input int unsigned kk);
    case (kk)
      1:       return {32'd1024, 32'd686};
      2:       return {32'd512,  32'd1372};
      3:       return {32'd1536, 32'd228};
      default: return {32'h1000_0000 | kk, 32'h2000_0000 | kk};
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.gen_valid <= 1'b0;
      bus.gen_out_0 <= '0;
      bus.gen_out_1 <= '0;
      core_cnt      <= 0;
    end else begin
      bus.gen_valid <= 1'b0;
      if (bus.gen_reseed_enable) begin
        core_k <= bus.gen_seed;
      end else if (bus.gen_pop_enable) begin
        core_k <= core_k + 1;
        if (core_lat <= 1) begin
          if (!core_stall) begin
            bus.gen_valid <= 1'b1;
            {bus.gen_out_0, bus.gen_out_1} <= core_pt(core_k + 1);
          end
        end else begin
          core_cnt <= core_lat - 1;
        end
      end else if (core_cnt != 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1 && !core_stall) begin
          bus.gen_valid <= 1'b1;
          {bus.gen_out_0, bus.gen_out_1} <= core_pt(core_k);
        end
      end
    end
  end

  always @(posedge clk) if (bus.gen_pop_enable) pops <= pops + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step negedges until pt_valid or the bound; returns cycles stepped.
  task automatic wait_pt(input int unsigned bound, output int unsigned n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.pt_valid && n < bound);
  endtask

  task automatic wait_pop(input int unsigned bound);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.gen_pop_enable && n < bound);
    chk("pop_seen", {63'd0, bus.gen_pop_enable}, 64'd1);
  endtask

  task automatic wait_idle(input int unsigned bound);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < bound);
    chk("idle_reached", {63'd0, bus.busy}, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int unsigned  lat;
  logic [31:0]  hx, hy, served0;
  logic [1:0]   hid;
  bit           stable, pop_seen;
  int unsigned  pops0;
  logic [1:0]   order [5];

  initial begin
    bus.req          = '0;
    bus.req_len      = '0;
    bus.reseed_req   = 1'b0;
    bus.reseed_value = '0;
    bus.pt_ready     = 1'b0;
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
    do_reset();

    // Reset state
    chk("rst_grant",    {60'd0, bus.grant}, 64'd0);
    chk("rst_busy",     {63'd0, bus.busy}, 64'd0);
    chk("rst_pt_valid", {63'd0, bus.pt_valid}, 64'd0);
    chk("rst_served",   {32'd0, bus.pts_served}, 64'd0);
    chk("rst_seed",     {32'd0, bus.gen_seed}, 64'd0);
    chk("rst_pop",      {63'd0, bus.gen_pop_enable}, 64'd0);

    // 1: three-point burst for requester 0
    bus.pt_ready = 1'b1;
    bus.req_len[7:0] = 8'd2;
    bus.req = 4'b0001;
    wait_pt(20, lat);
    bus.req = 4'b0000;
    chk("t1_lat0",   lat, 64'd3);
    chk("t1_id0",    {62'd0, bus.pt_id}, 64'd0);
    chk("t1_grant",  {60'd0, bus.grant}, 64'd1);
    chk("t1_xy0",    {bus.pt_x, bus.pt_y}, {32'd1024, 32'd686});
    chk("t1_last0",  {63'd0, bus.pt_last}, 64'd0);
    wait_pt(20, lat);
    chk("t1_lat1",   lat, 64'd3);
    chk("t1_xy1",    {bus.pt_x, bus.pt_y}, {32'd512, 32'd1372});
    chk("t1_last1",  {63'd0, bus.pt_last}, 64'd0);
    wait_pt(20, lat);
    chk("t1_xy2",    {bus.pt_x, bus.pt_y}, {32'd1536, 32'd228});
    chk("t1_last2",  {63'd0, bus.pt_last}, 64'd1);
    @(negedge clk);
    chk("t1_served", {32'd0, bus.pts_served}, 64'd3);
    chk("t1_idle",   {63'd0, bus.busy}, 64'd0);
    chk("t1_gnt0",   {60'd0, bus.grant}, 64'd0);

    // 2: all requesters, single-point bursts, round-robin from 0
    do_reset();
    bus.req_len = '0;
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_pt(20, lat);
      if (i == 4) bus.req = 4'b0000;
      chk("t2_valid", {63'd0, bus.pt_valid}, 64'd1);
      chk("t2_id",    {62'd0, bus.pt_id}, {62'd0, order[i]});
      chk("t2_grant", {60'd0, bus.grant}, 64'd1 << order[i]);
    end
    wait_idle(20);

    // 3: reseed and request in the same cycle; reseed goes first
    bus.reseed_value = 32'd5;
    bus.reseed_req = 1'b1;
    bus.req = 4'b0010;
    @(negedge clk);
    bus.reseed_req = 1'b0;
    chk("t3_ack",    {63'd0, bus.reseed_ack}, 64'd1);
    chk("t3_rsen",   {63'd0, bus.gen_reseed_enable}, 64'd1);
    chk("t3_seed",   {32'd0, bus.gen_seed}, 64'd5);
    chk("t3_nogrnt", {60'd0, bus.grant}, 64'd0);
    @(negedge clk);
    chk("t3_ack_off", {63'd0, bus.reseed_ack}, 64'd0);
    wait_pt(20, lat);
    bus.req = 4'b0000;
    chk("t3_id",  {62'd0, bus.pt_id}, 64'd1);
    chk("t3_xy",  {bus.pt_x, bus.pt_y}, {32'h1000_0006, 32'h2000_0006});
    wait_idle(20);

    // 4: backpressure for 20 cycles on a four-point burst
    bus.pt_ready = 1'b0;
    bus.req_len[23:16] = 8'd3;
    served0 = bus.pts_served;
    pops0 = pops;
    bus.req = 4'b0100;
    wait_pt(20, lat);
    bus.req = 4'b0000;
    chk("t4_xy0", {bus.pt_x, bus.pt_y}, {32'h1000_0007, 32'h2000_0007});
    hx = bus.pt_x; hy = bus.pt_y; hid = bus.pt_id;
    stable = 1'b1; pop_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.pt_x !== hx || bus.pt_y !== hy || bus.pt_id !== hid || !bus.pt_valid) stable = 1'b0;
      if (bus.gen_pop_enable) pop_seen = 1'b1;
    end
    chk("t4_stable", {63'd0, stable}, 64'd1);
    chk("t4_nopop",  {63'd0, pop_seen}, 64'd0);
    chk("t4_pops1",  pops - pops0, 64'd1);
    bus.pt_ready = 1'b1;
    wait_idle(40);
    chk("t4_pops",   pops - pops0, 64'd4);
    chk("t4_served", {32'd0, bus.pts_served - served0}, 64'd4);

    // 5a: core never answers -> timeout 64 cycles after the pop
    core_stall = 1'b1;
    bus.req_len = '0;
    bus.req_len[31:24] = 8'd1;
    bus.req = 4'b1000;
    wait_pop(10);
    bus.req = 4'b0000;
    repeat (63) @(negedge clk);
    chk("t5_te_early", {63'd0, bus.timeout_err}, 64'd0);
    @(negedge clk);
    chk("t5_te",       {63'd0, bus.timeout_err}, 64'd1);
    @(negedge clk);
    chk("t5_te_pulse", {63'd0, bus.timeout_err}, 64'd0);
    chk("t5_idle",     {63'd0, bus.busy}, 64'd0);
    chk("t5_gnt0",     {60'd0, bus.grant}, 64'd0);

    // 5b: normal service afterwards; rr moved past 3 so requester 0 wins over 3
    core_stall = 1'b0;
    bus.req_len = '0;
    bus.req = 4'b1001;
    wait_pt(20, lat);
    bus.req = 4'b0000;
    chk("t5_next_id", {62'd0, bus.pt_id}, 64'd0);
    chk("t5_next_xy", {bus.pt_x, bus.pt_y}, {32'h1000_000C, 32'h2000_000C});
    wait_idle(20);

    // 5c: valid exactly on the 64th WAIT cycle is accepted
    core_lat = 64;
    bus.req = 4'b0010;
    wait_pop(10);
    bus.req = 4'b0000;
    repeat (63) @(negedge clk);
    @(negedge clk);
    chk("t5_edge_valid", {63'd0, bus.gen_valid}, 64'd1);
    chk("t5_edge_te",    {63'd0, bus.timeout_err}, 64'd0);
    @(negedge clk);
    chk("t5_edge_pt",    {63'd0, bus.pt_valid}, 64'd1);
    chk("t5_edge_xy",    {bus.pt_x, bus.pt_y}, {32'h1000_000D, 32'h2000_000D});
    core_lat = 1;
    wait_idle(20);

    // 6: async reset while in OUT with five points remaining
    bus.pt_ready = 1'b0;
    bus.req_len[7:0] = 8'd5;
    bus.req = 4'b0001;
    wait_pt(20, lat);
    bus.req = 4'b0000;
    bus.pt_ready = 1'b1;
    @(negedge clk);
    bus.pt_ready = 1'b0;
    wait_pt(20, lat);
    chk("t6_in_out", {63'd0, bus.pt_valid}, 64'd1);
    chk("t6_last",   {63'd0, bus.pt_last}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_pt_valid", {63'd0, bus.pt_valid}, 64'd0);
    chk("t6_grant",    {60'd0, bus.grant}, 64'd0);
    chk("t6_busy",     {63'd0, bus.busy}, 64'd0);
    chk("t6_served",   {32'd0, bus.pts_served}, 64'd0);
    chk("t6_x",        {32'd0, bus.pt_x}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.pt_ready = 1'b1;
    bus.req_len = '0;
    bus.req = 4'b1001;
    wait_pt(20, lat);
    bus.req = 4'b0000;
    chk("t6_after_id", {62'd0, bus.pt_id}, 64'd0);
    wait_idle(20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
